// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-control inputs and PC/status outputs of the next-PC sequencer
interface pc_sequencer_if;
  logic        stall, br_taken, jmp, exc_req, eret;
  logic [31:0] br_target, jmp_target, epc;
  logic [31:0] pc, bad_addr;
  logic [9:0]  im_index;
  logic        in_slot, fetch_exc;
  modport master (output stall, br_taken, br_target, jmp, jmp_target, exc_req, eret, epc,
                  input  pc, im_index, in_slot, fetch_exc, bad_addr);
  modport slave  (input  stall, br_taken, br_target, jmp, jmp_target, exc_req, eret, epc,
                  output pc, im_index, in_slot, fetch_exc, bad_addr);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: MIPS next-PC controller with one delay slot, exception entry and eret
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic clk,
  input  logic reset,
  pc_sequencer_if.slave bus
);
  typedef enum logic {RUN, SLOT} state_t;
  state_t      r_state, w_state;
  logic [31:0] r_pc, w_pc, r_tgt, w_tgt, r_bad, w_bad;
  logic        r_fexc, w_fexc;
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_tgt   = r_tgt;
    w_bad   = r_bad;
    w_fexc  = 1'b0;
    if (bus.exc_req || bus.eret) begin
      w_pc    = bus.exc_req ? EXC_VECTOR : bus.epc;
      w_state = RUN;
      w_tgt   = '0;
    end else if (!bus.stall) begin
      if (r_state == RUN) begin
        w_pc = r_pc + 32'd4;
        if (bus.br_taken || bus.jmp) begin
          w_tgt   = bus.br_taken ? bus.br_target : bus.jmp_target;
          w_state = SLOT;
        end
      end else begin
        // misaligned targets become exception entry instead of a fetch
        w_pc    = (r_tgt[1:0] == 2'b00) ? r_tgt : EXC_VECTOR;
        w_bad   = (r_tgt[1:0] == 2'b00) ? r_bad : r_tgt;
        w_fexc  = (r_tgt[1:0] != 2'b00);
        w_state = RUN;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_pc    <= RESET_PC;
      r_tgt   <= '0;
      r_bad   <= '0;
      r_fexc  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_tgt   <= w_tgt;
      r_bad   <= w_bad;
      r_fexc  <= w_fexc;
    end
  end
  assign bus.pc        = r_pc;
  assign bus.im_index  = r_pc[11:2];
  assign bus.in_slot   = (r_state == SLOT);
  assign bus.fetch_exc = r_fexc;
  assign bus.bad_addr  = r_bad;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Next-PC controller for the MIPS fetch stage. It owns the program counter and decides each cycle whether to advance, hold, or redirect. Redirect sources are sequential fetch, branch/jump with one architectural delay slot, exception entry and `eret`. The instruction memory is indexed directly from its outputs, and it reports misaligned redirect targets as fetch exceptions.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000, PC value after reset.
- `EXC_VECTOR`, 32'h0000_4180, exception entry address.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold PC and state this cycle.
- `br_taken`  in  1  taken conditional branch in the current instruction.
- `br_target`  in  32  branch destination.
- `jmp`  in  1  unconditional jump (j/jal/jr) in the current instruction.
- `jmp_target`  in  32  jump destination.
- `exc_req`  in  1  exception/interrupt entry request.
- `eret`  in  1  return from exception.
- `epc`  in  32  return address for `eret`.
- `pc`  out  32  current fetch address (registered).
- `im_index`  out  10  `pc[11:2]`, instruction-memory word index.
- `in_slot`  out  1  current `pc` is a delay-slot instruction.
- `fetch_exc`  out  1  one-cycle pulse: misaligned redirect was converted to exception entry.
- `bad_addr`  out  32  last offending target, sticky until next fetch exception or reset.

## Operation
- States: RUN (sequential fetch) and SLOT (delay slot in flight, target latched in internal `tgt`).
- Per-cycle priority, highest first:
  - `exc_req`: `pc<=EXC_VECTOR`, state RUN, `tgt` discarded. Ignores `stall`.
  - `eret`: `pc<=epc`, state RUN, `tgt` discarded. Ignores `stall`.
  - `stall`: everything holds.
  - State action.
- RUN, no redirect: `pc<=pc+4`.
- RUN with `br_taken` or `jmp`: latch target, `pc<=pc+4` (delay slot), go to SLOT.
  - Both asserted: `br_target` wins.
- SLOT:
  - `tgt[1:0]==0`: `pc<=tgt`, go to RUN.
  - Otherwise: `pc<=EXC_VECTOR`, `bad_addr<=tgt`, `fetch_exc<=1` for one cycle, go to RUN.
  - `br_taken`/`jmp` arriving in SLOT are ignored (branch in delay slot is undefined by the ISA, and is dropped).
- `in_slot` is 1 exactly while state is SLOT.
- `eret` with misaligned `epc` is not checked; `pc` takes it verbatim.
- Arithmetic: `pc+4` is modulo 2^32. `im_index` wraps modulo 1024 words; no range fault.

## Timing
- Reset values, applied asynchronously on `reset`=0: `pc=RESET_PC`, `im_index=RESET_PC[11:2]`, state RUN, `in_slot=0`, `fetch_exc=0`, `bad_addr=0`, `tgt=0`.
- All outputs are registered or derived from registers. No combinational path from inputs to outputs.
- Branch/jump latency:
  - Request at cycle N (not stalled) gives `pc=slot` at N+1.
  - Target appears at the first unstalled edge after N+1 (N+2 with no stall).
- `exc_req`/`eret` at cycle N: new `pc` at N+1, including mid-SLOT and while stalled.
- `fetch_exc` is high for exactly the cycle in which `pc==EXC_VECTOR` first appears from a misaligned target. Stall does not extend it.
- Reset released mid-sequence: operation restarts in RUN from `RESET_PC`; a previously latched target is never used.

## Test plan
- Reset then 4 free cycles: `pc` = 0x3000, 0x3004, 0x3008, 0x300C; `in_slot`=0; `im_index` = 0,1,2,3.
- At `pc`=0x3010, pulse `br_taken`, `br_target`=0x3100:
  - Next `pc` = 0x3014 with `in_slot`=1.
  - Then `pc` = 0x3100 with `in_slot`=0.
- Jump to 0x3040 with `stall` high for 3 cycles during SLOT:
  - `pc` holds 0x3014-equivalent slot address and `in_slot`=1 throughout.
  - Redirects to 0x3040 on the first unstalled edge.
- `jmp_target`=0x3042:
  - After the slot, `pc`=0x4180, `fetch_exc`=1 for one cycle, `bad_addr`=0x3042.
- `exc_req` in the same cycle as `stall` and while in SLOT:
  - Next `pc`=0x4180, `in_slot`=0, latched target never fetched.
  - Then `eret` with `epc`=0x3020 gives `pc`=0x3020.
- Drive `reset`=0 asynchronously mid-cycle while in SLOT: `pc` immediately 0x3000, `in_slot`=0, `bad_addr`=0.
